// File: rtl/bus_arbiter_rr16.sv
// Round-robin arbiter/sequencer for the 16-source datapath mux, with a hold limit and a one-cycle dead gap.
// Optional ARB_LOCK_EN adds a lock input that suspends the hold limit while asserted in GRANT.
module bus_arbiter_rr16 #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] req,
`ifdef ARB_LOCK_EN
  input  logic        lock,
`endif
  output logic [15:0] grant,
  output logic [3:0]  sel,
  output logic        mux_en,
  output logic        busy,
  output logic        preempt
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t           state_q, state_d;
  logic [3:0]       ptr_q, ptr_d;
  logic [3:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      grant_q, grant_d;
  logic             preempt_q, preempt_d;

  logic             lock_on;
  logic             found;
  logic [3:0]       win;
  logic [3:0]       idx;
  logic             owner_req;
  logic             others;
  logic             hold_hit;

`ifdef ARB_LOCK_EN
  assign lock_on = lock;
`else
  assign lock_on = 1'b0;
`endif

  // First requester at or after ptr, wrapping 15->0.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      idx = ptr_q + 4'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign owner_req = req[sel_q];
  assign others    = |(req & ~(16'h0001 << sel_q));
  assign hold_hit  = owner_req && (cnt_q == CNT_W'(MAX_HOLD)) && others && !lock_on;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    preempt_d = 1'b0;
    case (state_q)
      IDLE, GAP: begin
        if (found) begin
          state_d = GRANT;
          sel_d   = win;
          grant_d = 16'h0001 << win;
          cnt_d   = CNT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        // A drop takes precedence over the hold limit, so preempt stays low then.
        if (!owner_req || hold_hit) begin
          state_d   = GAP;
          grant_d   = '0;
          ptr_d     = sel_q + 4'd1;
          preempt_d = owner_req;
        end else if (cnt_q != CNT_W'(MAX_HOLD)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      sel_q     <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      preempt_q <= preempt_d;
    end
  end

  assign grant   = grant_q;
  assign sel     = sel_q;
  assign mux_en  = (state_q == GRANT);
  assign busy    = (state_q != IDLE);
  assign preempt = preempt_q;

endmodule

// File: tb/tb_bus_arbiter_rr16.sv
// Self-checking bench for bus_arbiter_rr16: vector table, hand sequences and a random run against a reference model.
module tb_bus_arbiter_rr16;
  localparam int unsigned MAXH = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] req;
  logic [15:0] grant;
  logic [3:0]  sel;
  logic        mux_en, busy, preempt;
`ifdef ARB_LOCK_EN
  logic        lock;
`endif

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Reference model: owner index (-1 when nobody owns), pending gap flag, rotation pointer.
  int m_owner, m_sel, m_ptr, m_hold;
  bit m_gap, m_pre;

  bus_arbiter_rr16 #(.MAX_HOLD(MAXH), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .req(req),
`ifdef ARB_LOCK_EN
    .lock(lock),
`endif
    .grant(grant), .sel(sel), .mux_en(mux_en), .busy(busy), .preempt(preempt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] r;
    logic [15:0] g;
    logic [3:0]  s;
    logic        m, b, p;
  } vec_t;

  vec_t tbl [11];

  function automatic int pick(input logic [15:0] r, input int from);
    for (int k = 0; k < 16; k++) begin
      if (r[(from + k) % 16]) return (from + k) % 16;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_sel = 0; m_ptr = 0; m_hold = 0; m_gap = 0; m_pre = 0;
  endtask

  task automatic model_step(input logic [15:0] r, input bit lk);
    bit rivals;
    m_pre = 0;
    if (m_owner >= 0) begin
      rivals = (r & ~(16'h0001 << m_owner)) != 16'h0;
      if (!r[m_owner] || (m_hold >= MAXH && rivals && !lk)) begin
        m_pre   = r[m_owner];
        m_ptr   = (m_owner + 1) % 16;
        m_owner = -1;
        m_gap   = 1;
      end else if (m_hold < MAXH) begin
        m_hold++;
      end
    end else if (r != 16'h0) begin
      m_owner = pick(r, m_ptr);
      m_sel   = m_owner;
      m_hold  = 1;
      m_gap   = 0;
    end else begin
      m_gap = 0;
    end
  endtask

  function automatic logic [22:0] model_out();
    logic [15:0] g;
    logic [3:0]  s;
    g = (m_owner >= 0) ? (16'h0001 << m_owner) : 16'h0;
    s = 4'(m_sel);
    return {g, s, (m_owner >= 0), (m_owner >= 0) || m_gap, m_pre};
  endfunction

  function automatic logic [22:0] dut_out();
    return {grant, sel, mux_en, busy, preempt};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cycle(input logic [15:0] r, input bit lk);
    req = r;
`ifdef ARB_LOCK_EN
    lock = lk;
`endif
    model_step(r, lk);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0;
`ifdef ARB_LOCK_EN
    lock = 1'b0;
`endif
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [15:0] r;
    int          pos, own, bad;
    bit          lk;

    tbl[0]  = '{16'h8001, 16'h0001, 4'd0,  1'b1, 1'b1, 1'b0};
    tbl[1]  = '{16'h8000, 16'h0000, 4'd0,  1'b0, 1'b1, 1'b0};
    tbl[2]  = '{16'h8000, 16'h8000, 4'd15, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{16'h0000, 16'h0000, 4'd15, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{16'h0000, 16'h0000, 4'd15, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{16'h0001, 16'h0001, 4'd0,  1'b1, 1'b1, 1'b0};
    tbl[6]  = '{16'h0000, 16'h0000, 4'd0,  1'b0, 1'b1, 1'b0};
    tbl[7]  = '{16'h0000, 16'h0000, 4'd0,  1'b0, 1'b0, 1'b0};
    tbl[8]  = '{16'h0003, 16'h0002, 4'd1,  1'b1, 1'b1, 1'b0};
    tbl[9]  = '{16'h0000, 16'h0000, 4'd1,  1'b0, 1'b1, 1'b0};
    tbl[10] = '{16'h0000, 16'h0000, 4'd1,  1'b0, 1'b0, 1'b0};

    reset_n = 1'b0;
    req = '0;
`ifdef ARB_LOCK_EN
    lock = 1'b0;
`endif
    #2;
    check("reset_outputs", 32'(dut_out()), 32'h0);
    do_reset();

    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].r, 1'b0);
      check($sformatf("vec%0d", i), 32'(dut_out()),
            32'({tbl[i].g, tbl[i].s, tbl[i].m, tbl[i].b, tbl[i].p}));
    end

    // Two constant requesters alternate: 8 owned cycles then one preempt gap.
    do_reset();
    for (int e = 1; e <= 40; e++) begin
      cycle(16'h0003, 1'b0);
      pos = (e - 1) % 9;
      own = ((e - 1) / 9) % 2;
      check($sformatf("hold_e%0d", e), 32'(dut_out()),
            32'({(pos < 8) ? (16'h0001 << own) : 16'h0, 4'(own), pos < 8, 1'b1, pos == 8}));
    end

    do_reset();
    bad = 0;
    for (int e = 0; e < 50; e++) begin
      cycle(16'h0020, 1'b0);
      if (dut_out() !== {16'h0020, 4'd5, 1'b1, 1'b1, 1'b0}) bad++;
    end
    check("single_req_bad_cycles", 32'(bad), 32'd0);

    // Move ptr off zero, then reset asynchronously while source 3 owns the bus.
    do_reset();
    cycle(16'h0004, 1'b0);
    cycle(16'h0000, 1'b0);
    cycle(16'h0008, 1'b0);
    check("pre_reset_owner", 32'(dut_out()), 32'({16'h0008, 4'd3, 1'b1, 1'b1, 1'b0}));
    #3 reset_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'(dut_out()), 32'h0);
    req = '0;
    #1 reset_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    cycle(16'h0011, 1'b0);
    check("post_reset_ptr", 32'(dut_out()), 32'({16'h0001, 4'd0, 1'b1, 1'b1, 1'b0}));

`ifdef ARB_LOCK_EN
    do_reset();
    bad = 0;
    for (int e = 0; e < 20; e++) begin
      cycle(16'h0003, 1'b1);
      if (dut_out() !== {16'h0001, 4'd0, 1'b1, 1'b1, 1'b0}) bad++;
    end
    check("lock_hold_bad_cycles", 32'(bad), 32'd0);
    cycle(16'h0003, 1'b0);
    check("lock_release_preempt", 32'(dut_out()), 32'({16'h0000, 4'd0, 1'b0, 1'b1, 1'b1}));
    cycle(16'h0003, 1'b0);
    check("lock_next_owner", 32'(dut_out()), 32'({16'h0002, 4'd1, 1'b1, 1'b1, 1'b0}));
`endif

    do_reset();
    r  = '0;
    lk = 1'b0;
    for (int e = 0; e < 600; e++) begin
      if ($urandom_range(0, 3) == 0)
        r = 16'($urandom) & (($urandom_range(0, 1) == 1) ? 16'h000F : 16'hFFFF);
      else if ($urandom_range(0, 5) == 0)
        r[$urandom_range(0, 15)] = 1'b0;
`ifdef ARB_LOCK_EN
      if ($urandom_range(0, 7) == 0) lk = ~lk;
`endif
      cycle(r, lk);
      check($sformatf("rand%0d", e), 32'(dut_out()), 32'(model_out()));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
